regfile_flags: RTL and testbench

- Parametrised successor to the 16-bit CPU register file: configurable width and depth, optional hardwired-zero r0, and optional write-to-read bypass.
- Holds the processor status flags (C, L, F, Z, N) captured from the ALU.
- Has a hardware bulk-clear sequencer that zeroes every register, one per cycle, while reporting busy and done to the controller.
- Sits between the ALU/alucontrol datapath and the control FSM; rd1/rd2 feed ALU Rsrc/Rdes.

---
 rtl/regfile_flags.sv | 130 +++++++++++++
 tb/tb_regfile_flags.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_flags.sv
// Parametrised register file with ALU status flags and a bulk-clear sequencer.
// While a clear runs, writes, flag captures and clear requests are ignored.

module regfile_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // The clear wins; a write cannot happen while the clear is running anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module regfile_flags #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              flag_we,
  input  logic [4:0]        flags_in,
  output logic [4:0]        flags,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_dropped
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS-1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            cnt, cnt_nxt;
  logic                         start;
  logic                         wr_en;
  logic [NREGS-1:0][WIDTH-1:0]  regs;

  // Sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          start     = 1'b1;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);
  assign wr_en    = regwrite && !clr_busy;

  // One storage cell per register; a hardwired r0 has no flops at all.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    if (R0_ZERO != 0 && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      regfile_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && (wa == IDX)),
        .clr   (clr_busy && (cnt == IDX)),
        .d     (wd),
        .q     (regs[i])
      );
    end
  end

  // Starting a clear zeroes the flags on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= '0;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= regwrite && clr_busy;
      if (start)                    flags <= '0;
      else if (flag_we && !clr_busy) flags <= flags_in;
    end
  end

  function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR_W-1:0] ra);
    if (R0_ZERO != 0 && ra == '0)            rd_sel = '0;
    else if (BYPASS != 0 && wr_en && wa == ra) rd_sel = wd;
    else                                     rd_sel = regs[ra];
  endfunction

  assign rd1 = rd_sel(ra1);
  assign rd2 = rd_sel(ra2);

endmodule

// File: tb/tb_regfile_flags.sv
// Randomised + directed bench: three parameter variants share one stimulus
// stream and are checked every cycle against a behavioural model.

module tb_regfile_flags;
  localparam int W = 16, AW = 4, N = 16, NI = 3;
  localparam bit BYP [NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit R0Z [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          regwrite, flag_we, clr_req;
  logic [AW-1:0] wa, ra1, ra2;
  logic [W-1:0]  wd;
  logic [4:0]    flags_in;

  logic [NI-1:0][W-1:0] rd1v, rd2v;
  logic [NI-1:0][4:0]   flagsv;
  logic [NI-1:0]        busyv, donev, wrdv;

  int checks = 0, errors = 0;

  regfile_flags #(.WIDTH(W), .ADDR_W(AW), .BYPASS(1), .R0_ZERO(0)) u0 (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1v[0]), .rd2(rd2v[0]), .flag_we(flag_we), .flags_in(flags_in), .flags(flagsv[0]),
    .clr_req(clr_req), .clr_busy(busyv[0]), .clr_done(donev[0]), .wr_dropped(wrdv[0]));
  regfile_flags #(.WIDTH(W), .ADDR_W(AW), .BYPASS(0), .R0_ZERO(0)) u1 (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1v[1]), .rd2(rd2v[1]), .flag_we(flag_we), .flags_in(flags_in), .flags(flagsv[1]),
    .clr_req(clr_req), .clr_busy(busyv[1]), .clr_done(donev[1]), .wr_dropped(wrdv[1]));
  regfile_flags #(.WIDTH(W), .ADDR_W(AW), .BYPASS(1), .R0_ZERO(1)) u2 (
    .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1v[2]), .rd2(rd2v[2]), .flag_we(flag_we), .flags_in(flags_in), .flags(flagsv[2]),
    .clr_req(clr_req), .clr_busy(busyv[2]), .clr_done(donev[2]), .wr_dropped(wrdv[2]));

  // ---------------- behavioural model ----------------
  logic [W-1:0] mem [NI][N];
  logic [4:0]   fl_m;
  int           pos;
  bit           clearing, done_m, wrd_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) for (int r = 0; r < N; r++) mem[k][r] = '0;
      fl_m = '0; pos = 0; clearing = 0; done_m = 0; wrd_m = 0;
    end else begin
      bit was_busy, was_done;
      was_busy = clearing;
      was_done = done_m;
      wrd_m  = regwrite && was_busy;
      done_m = 0;
      if (was_busy) begin
        for (int k = 0; k < NI; k++) mem[k][pos] = '0;
        pos++;
        if (pos == N) begin clearing = 0; done_m = 1; end
      end else begin
        if (regwrite)
          for (int k = 0; k < NI; k++)
            if (!(R0Z[k] && wa == 0)) mem[k][wa] = wd;
        if (flag_we) fl_m = flags_in;
        if (!was_done && clr_req) begin clearing = 1; pos = 0; fl_m = '0; end
      end
    end
  end

  function automatic logic [W-1:0] exp_rd(int k, logic [AW-1:0] ra);
    if (R0Z[k] && ra == 0)                            return '0;
    if (BYP[k] && regwrite && !clearing && wa == ra)  return wd;
    return mem[k][ra];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rd1[%0d]", k),   32'(rd1v[k]),   32'(exp_rd(k, ra1)));
      chk($sformatf("rd2[%0d]", k),   32'(rd2v[k]),   32'(exp_rd(k, ra2)));
      chk($sformatf("flags[%0d]", k), 32'(flagsv[k]), 32'(fl_m));
      chk($sformatf("busy[%0d]", k),  32'(busyv[k]),  32'(clearing));
      chk($sformatf("done[%0d]", k),  32'(donev[k]),  32'(done_m));
      chk($sformatf("wrd[%0d]", k),   32'(wrdv[k]),   32'(wrd_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();  @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic idle_in();
    regwrite = 0; flag_we = 0; clr_req = 0;
    wa = 0; wd = 0; ra1 = 0; ra2 = 0; flags_in = 0;
  endtask

  // Runs a clear from a one-cycle clr_req and returns the busy-cycle count.
  task automatic run_clear(input bool_pin, output int busy_n, output bit done_seen);
    clr_req = 1; cyc(); clr_req = 0;
    busy_n = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (donev[0]) begin done_seen = 1; break; end
      if (busyv[0]) busy_n++;
      if (bool_pin && busy_n == 3) chk("mid_clear_r15", 32'(rd1v[0]), 32'hFFFF);
      if (bool_pin && busy_n == 5) begin
        regwrite = 1; wa = 7; wd = 16'h1234; flag_we = 1; flags_in = 5'h1F;
      end
      if (bool_pin && busy_n == 6) begin
        chk("wr_dropped_pulse", 32'(wrdv[0]), 32'd1);
        regwrite = 0; flag_we = 0; wa = 0; wd = 0;
      end
      cyc();
    end
    if (!done_seen) chk("clear_timeout", 32'd0, 32'd1);
  endtask

  int busy_n; bit done_seen;

  initial begin
    idle_in();
    #12 rst_n = 1;
    mid();
    chk("reset_rd1", 32'(rd1v[0]), 32'h0);
    chk("reset_flags", 32'(flagsv[0]), 32'h0);
    chk("reset_busy", 32'(busyv[0]), 32'h0);

    // Basic writes and reads
    cyc();
    regwrite = 1; wa = 3; wd = 16'h000A; cyc();
    wa = 2; cyc();
    regwrite = 0; ra1 = 3; ra2 = 2; mid();
    chk("t1_rd1", 32'(rd1v[1]), 32'h000A);
    chk("t1_rd2", 32'(rd2v[1]), 32'h000A);
    cyc();
    regwrite = 1; wa = 1; wd = 16'h07FF; cyc();
    wa = 2; wd = 16'h03FF; cyc();
    regwrite = 0; ra1 = 1; ra2 = 2; mid();
    chk("t1b_rd1", 32'(rd1v[0]), 32'h07FF);
    chk("t1b_rd2", 32'(rd2v[0]), 32'h03FF);

    // Bypass vs. no bypass
    cyc();
    regwrite = 1; wa = 5; wd = 16'hBEEF; ra1 = 5; mid();
    chk("t2_bypass", 32'(rd1v[0]), 32'hBEEF);
    chk("t2_nobypass", 32'(rd1v[1]), 32'h0000);
    cyc(); regwrite = 0; mid();
    chk("t2_nobypass_after", 32'(rd1v[1]), 32'hBEEF);

    // Hardwired r0
    cyc();
    regwrite = 1; wa = 0; wd = 16'hFFFF; ra1 = 0; mid();
    chk("t3_r0_comb", 32'(rd1v[2]), 32'h0);
    cyc(); regwrite = 0; mid();
    chk("t3_r0_held", 32'(rd1v[2]), 32'h0);
    chk("t3_no_drop", 32'(wrdv[2]), 32'h0);
    chk("t3_r0_plain", 32'(rd1v[0]), 32'hFFFF);

    // Fill, set flags, clear
    cyc();
    for (int r = 0; r < N; r++) begin regwrite = 1; wa = AW'(r); wd = 16'hFFFF; cyc(); end
    regwrite = 0; flag_we = 1; flags_in = 5'b10101; cyc();
    flag_we = 0; ra1 = 15; mid();
    chk("t4_flags_set", 32'(flagsv[0]), 32'b10101);
    cyc();
    run_clear(1'b1, busy_n, done_seen);
    chk("t4_busy_len", 32'(busy_n), 32'd16);
    chk("t4_done_seen", 32'(done_seen), 32'd1);
    for (int r = 0; r < N; r++) begin ra1 = AW'(r); #1 chk($sformatf("t4_reg%0d", r), 32'(rd1v[0]), 32'h0); end
    chk("t4_flags_clr", 32'(flagsv[0]), 32'h0);
    ra1 = 7; #1 chk("t5_reg7", 32'(rd1v[0]), 32'h0);

    // Async reset mid-clear
    cyc();
    for (int r = 0; r < N; r++) begin regwrite = 1; wa = AW'(r); wd = AW'(r) * 16'h0111; cyc(); end
    regwrite = 0; flag_we = 1; flags_in = 5'b01011; cyc(); flag_we = 0;
    clr_req = 1; cyc(); clr_req = 0;
    repeat (4) cyc();
    #1 rst_n = 0;
    #1 chk("t6_busy_rst", 32'(busyv[0]), 32'h0);
    chk("t6_flags_rst", 32'(flagsv[0]), 32'h0);
    for (int r = 0; r < N; r++) begin ra1 = AW'(r); #0.1 chk($sformatf("t6_reg%0d", r), 32'(rd1v[0]), 32'h0); end
    #1 rst_n = 1;
    cyc();
    run_clear(1'b0, busy_n, done_seen);
    chk("t6_busy_len", 32'(busy_n), 32'd16);
    chk("t6_done_seen", 32'(done_seen), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      cyc();
      regwrite = 1'($urandom_range(0, 1));
      flag_we  = ($urandom_range(0, 3) == 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      wa = AW'($urandom); wd = W'($urandom);
      ra1 = AW'($urandom); ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      flags_in = 5'($urandom);
    end
    cyc(); idle_in(); mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
